data_mem_ctrl: RTL
==================

# data_mem_ctrl

Data-memory access controller that sits directly downstream of the pipelined CPU datapath's memory port (mem_ren/mem_wen/mem_addr/mem_dout/mem_din). It converts the datapath's single-cycle byte-addressed requests into word accesses on a synchronous block RAM with configurable read latency. While a read is outstanding it stalls the core, and it flags misaligned or out-of-range accesses. It also keeps saturating read/write access counters for debug.

## Interface
- RAM_LATENCY, 1, read latency of the RAM in cycles (legal 1..4): ram_rdata is valid RAM_LATENCY cycles after ram_en with ram_we=0.
- ADDR_WIDTH, 10, RAM word-address width; RAM depth = 2^ADDR_WIDTH words.
- clk  in  1  main clock, all state on rising edge.
- cpu_rst  in  1  reset, asynchronous, active-high.
- mem_ren  in  1  read request from datapath (already gated by cpu_en/cpu_rst).
- mem_wen  in  1  write request from datapath.
- mem_addr  in  32  byte address.
- mem_dout  in  32  write data from datapath.
- mem_din  out  32  read data to datapath.
- mem_stall  out  1  core must hold pipeline and request stable while 1.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable (qualified by ram_en).
- ram_addr  out  ADDR_WIDTH  RAM word address = mem_addr[ADDR_WIDTH+1:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data.
- err_clr  in  1  clears mem_err.
- mem_err  out  1  sticky: a bad access occurred.
- err_addr  out  32  mem_addr of the first bad access since the last clear.
- rd_count  out  16  accepted reads, saturating at 16'hFFFF.
- wr_count  out  16  accepted writes, saturating at 16'hFFFF.

## Operation
- Bad access: mem_addr[1:0]≠0, or mem_addr[31:ADDR_WIDTH+2]≠0, or mem_ren&mem_wen both set.
  - A bad access never drives ram_en and never stalls.
  - If mem_err=0: set mem_err and capture err_addr.
  - A bad read returns mem_din=0 for that cycle.
- FSM states: IDLE, WAIT, DONE.
- IDLE, good write:
  - ram_en=ram_we=1, ram_wdata=mem_dout combinationally.
  - No stall; wr_count increments; stay in IDLE (posted write).
- IDLE, good read:
  - ram_en=1, ram_we=0, mem_stall=1.
  - Load the latency counter with RAM_LATENCY-1; go to WAIT.
- WAIT:
  - mem_stall=1, ram_en=0.
  - Counter decrements each cycle. When it is 0, capture ram_rdata into a data register and go to DONE.
- DONE:
  - mem_stall=0, mem_din=captured data.
  - rd_count increments. The request still present this cycle is treated as consumed and is not reissued.
  - Next state is IDLE.
- mem_din is 0 whenever the FSM is not in DONE.
- ram_addr and ram_wdata follow mem_addr and mem_dout combinationally in every state (don't-care when ram_en=0).
- err_clr:
  - Clears mem_err and err_addr to 0.
  - If a bad access occurs in the same cycle as err_clr, the set wins: mem_err=1 and err_addr=that address.
- Counters saturate and never wrap.

## Timing
- Reset (async assert, any state):
  - FSM goes to IDLE and any in-flight read data is discarded.
  - mem_stall=0, mem_din=0, ram_en=0, ram_we=0, mem_err=0, err_addr=0, rd_count=0, wr_count=0.
  - ram_addr/ram_wdata follow inputs.
- Read with latency L:
  - Cycle 0 (IDLE): issue.
  - Cycles 1..L: WAIT; ram_rdata is sampled at the end of cycle L.
  - Cycle L+1: DONE.
  - mem_stall is high for exactly L+1 cycles; the read occupies L+2 cycles in total.
- Write: one cycle, zero stall. Back-to-back writes are accepted every cycle.
- Read after read: the second read issues in the IDLE cycle immediately after DONE (one bubble).
- Write immediately after a read's DONE is issued in the next IDLE cycle; the RAM sees the read complete before the write.
- Requests arriving in WAIT are ignored (the core is stalled and holding the same read).

## Test plan
- Reset, then write 32'h1234_5678 to 0x10, then read 0x10 with RAM_LATENCY=1 → ram_addr=4, ram_we=1 for 1 cycle. Read: mem_stall high 2 cycles, mem_din=32'h1234_5678 in DONE, rd_count=1, wr_count=1.
- RAM_LATENCY=3, read 0x0 holding 32'hCAFE_F00D → mem_stall high exactly 4 cycles, ram_en pulses once, mem_din valid in cycle 4 only.
- Read 0x6 (misaligned) → no ram_en, no stall, mem_din=0, mem_err=1, err_addr=0x6. A later bad access at 0x8000_0000 leaves err_addr=0x6.
- err_clr asserted in the same cycle as a bad write to 0x3 → mem_err=1, err_addr=0x3. err_clr alone next cycle → mem_err=0, err_addr=0.
- Assert cpu_rst asynchronously mid-WAIT (RAM_LATENCY=4) → mem_stall drops immediately, state IDLE, counters 0. The next read completes normally.
- Force wr_count to 16'hFFFE, perform 3 writes → wr_count holds 16'hFFFF.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: turns the datapath's single-cycle byte-addressed memory requests into
// word accesses on a synchronous block RAM, stalling reads and flagging bad accesses.
module data_mem_ctrl #(
    parameter int RAM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  cpu_rst,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_dout,
    output logic [31:0]           mem_din,
    output logic                  mem_stall,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    input  logic                  err_clr,
    output logic                  mem_err,
    output logic [31:0]           err_addr,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RAM_LATENCY - 1);

    state_t      state;
    logic [1:0]  lat_cnt;
    logic [31:0] din_q;
    logic        in_idle;
    logic        access_bad;
    logic        good_rd;
    logic        good_wr;
    logic        err_hit;

    // Requests are only decoded in IDLE; in WAIT/DONE the core is holding the read in flight.
    always_comb begin
        in_idle    = (state == IDLE) && !cpu_rst;
        access_bad = (mem_ren || mem_wen) &&
                     ((mem_addr[1:0] != 2'b00) ||
                      ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0) ||
                      (mem_ren && mem_wen));
        good_rd    = in_idle && mem_ren && !access_bad;
        good_wr    = in_idle && mem_wen && !access_bad;
        err_hit    = in_idle && access_bad;
    end

    assign ram_en    = good_rd || good_wr;
    assign ram_we    = good_wr;
    assign mem_stall = good_rd || ((state == WAIT) && !cpu_rst);
    assign ram_addr  = mem_addr[ADDR_WIDTH+1:2];
    assign ram_wdata = mem_dout;
    assign mem_din   = din_q;

    // din_q is only non-zero during DONE, so mem_din comes straight from a register.
    always_ff @(posedge clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state    <= IDLE;
            lat_cnt  <= 2'd0;
            din_q    <= 32'd0;
            mem_err  <= 1'b0;
            err_addr <= 32'd0;
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (good_rd) begin
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        din_q <= ram_rdata;
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                DONE: begin
                    din_q <= 32'd0;
                    state <= IDLE;
                    if (rd_count != 16'hFFFF) begin
                        rd_count <= rd_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (good_wr && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end

            // A bad access in the same cycle as a clear is recorded rather than lost.
            if (err_clr) begin
                mem_err  <= err_hit;
                err_addr <= err_hit ? mem_addr : 32'd0;
            end else if (err_hit && !mem_err) begin
                mem_err  <= 1'b1;
                err_addr <= mem_addr;
            end
        end
    end

endmodule
